muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU, driven by the same decoded register operands A/B.
- Implements MULT, MULTU, DIV, DIVU into architectural HI/LO registers, plus MTHI/MTLO writes.
- Asserts busy so the control unit stalls the PC and any later MFHI/MFLO or muldiv op until the result is committed.

Parameters:
- DW, 32, operand/HI/LO width; iteration count equals DW.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  op request, sampled on clk edge.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- A  input  DW  rs operand (dividend/multiplicand; MTHI/MTLO source).
- B  input  DW  rt operand (divisor/multiplier).
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
- hi  output  DW  HI register.
- lo  output  DW  LO register.

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and datapath registers cleared. Reset mid-operation aborts the op; no HI/LO update.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op 0-3: latch A, B, op, and operand signs; load magnitudes (|A|, |B| for signed ops, raw values for unsigned); counter=0; go to CALC.
  - start=1 with op 4: hi<=A at that edge. Op 5: lo<=A. Stay IDLE; no busy, no done.
  - start=1 with op 6/7, or start=0: no action.
- CALC: one radix-2 step per cycle for exactly DW cycles, counter 0..DW-1; then go to FIX.
  - Multiply: shift-add on a 2*DW-bit unsigned product.
  - Divide: restoring division producing a DW-bit unsigned quotient and remainder.
- FIX: one cycle. Apply signs, write hi/lo at the end of the cycle, go to IDLE.
  - MULT: negate the 2*DW product if sign(A)^sign(B).
  - DIV: negate the quotient if sign(A)^sign(B); negate the remainder if sign(A). Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Writeback: multiply gives hi=product[2DW-1:DW], lo=product[DW-1:0]. Divide gives lo=quotient, hi=remainder.
- Timing: start sampled at edge 0. busy=1 in cycles 1..DW+1 (CALC + FIX, 33 cycles for DW=32). hi/lo show the result and done=1 in cycle DW+2; done=0 otherwise. busy is a registered output, low in IDLE.
- Arithmetic and width rules:
  - All intermediate arithmetic is modulo the stated widths.
  - DIV -2^31 / -1: lo=0x80000000, hi=0. No trap, no overflow flag.
  - Divide by zero (B==0, DIV or DIVU): lo=all ones, hi=A (original signed/unsigned A). Still takes the full DW+1 busy cycles.
- start while busy: ignored for all ops, including MTHI/MTLO. The control unit must hold the instruction until busy=0.
- Operand stability: A, B, op are captured at the start edge. Later input changes have no effect on the in-flight op.
- Back-to-back: start may be asserted in the done cycle (state IDLE) and is accepted. That edge's MTHI/MTLO write, or the next op's capture, takes effect without affecting the just-committed result.
- hi/lo are stable during CALC/FIX and hold their previous values until FIX commits.

Test Plan:
- Reset: drive rst=0 for 2 cycles mid-DIV, then release -> hi=0, lo=0, busy=0, done never pulses; a following MULTU 3*4 yields lo=12, hi=0.
- MULT A=0xFFFFFFFD (-3), B=5 -> busy high exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse 1 cycle. MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> lo=14, hi=2. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU A=0x1234, B=0 -> after 33 busy cycles lo=0xFFFFFFFF, hi=0x1234.
- Start while busy: issue MTHI A=0xDEAD and a second MULT during CALC -> both ignored; the first result is committed unchanged. MTHI A=0xBEEF in IDLE -> hi=0xBEEF next cycle, busy/done stay 0.
- Operand change: after start, toggle A/B and op every cycle during CALC -> result matches the captured operands. Start in the done cycle is accepted with correct timing.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the control unit (master) and the multiply/divide unit (slave).
// Carries the start request, opcode and operands in, and busy/done plus the HI/LO registers out.
interface muldiv_unit_if #(
    parameter int DW = 32
);
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (output start, op, A, B, input busy, done, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO plus single-cycle MTHI/MTLO writes.
// Latency DW+1 busy cycles, done pulses one cycle later; start is ignored while busy (no queueing).
module muldiv_unit #(
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div, neg_main, neg_rem, div_zero;
    logic [DW-1:0]   opnd;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   hi_q, lo_q;
    logic            busy_q, done_q;

    logic            sign_a, sign_b;
    logic [DW-1:0]   mag_a, mag_b;
    logic [DW-1:0]   mul_add;
    logic [DW:0]     mul_sum;
    logic [DW:0]     div_t, div_r;
    logic            div_ge;
    logic [2*DW-1:0] mul_nxt, div_nxt, prod_s;
    logic [DW-1:0]   quot_s, rem_s;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand conditioning: even opcodes (MULT/DIV) are the signed flavours.
    always_comb begin
        sign_a = ~bus.op[0] & bus.A[DW-1];
        sign_b = ~bus.op[0] & bus.B[DW-1];
        mag_a  = sign_a ? -bus.A : bus.A;
        mag_b  = sign_b ? -bus.B : bus.B;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_add = acc[0] ? opnd : '0;
        mul_sum = {1'b0, acc[2*DW-1:DW]} + {1'b0, mul_add};
        mul_nxt = {mul_sum, acc[DW-1:1]};
        div_t   = acc[2*DW-1:DW-1];
        div_ge  = div_t >= {1'b0, opnd};
        div_r   = div_ge ? (div_t - {1'b0, opnd}) : div_t;
        div_nxt = {div_r[DW-1:0], acc[DW-2:0], div_ge};
        prod_s  = neg_main ? -acc : acc;
        rem_s   = neg_rem ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
        if (div_zero)
            quot_s = '1;
        else
            quot_s = neg_main ? -acc[DW-1:0] : acc[DW-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start && !bus.op[2]) state_nxt = CALC;
            CALC: if (cnt == CW'(DW-1))         state_nxt = FIX;
            FIX:                                state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div   <= bus.op[1];
                                neg_main <= sign_a ^ sign_b;
                                neg_rem  <= sign_a;
                                div_zero <= bus.op[1] && (bus.B == '0);
                                cnt      <= '0;
                                if (bus.op[1]) begin
                                    opnd <= mag_b;
                                    acc  <= {{DW{1'b0}}, mag_a};
                                end else begin
                                    opnd <= mag_a;
                                    acc  <= {{DW{1'b0}}, mag_b};
                                end
                            end
                            3'd4:    hi_q <= bus.A;
                            3'd5:    lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div ? div_nxt : mul_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (is_div) begin
                        hi_q <= rem_s;
                        lo_q <= quot_s;
                    end else begin
                        hi_q <= prod_s[2*DW-1:DW];
                        lo_q <= prod_s[DW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: timing, signed/unsigned results, divide-by-zero,
// reset abort, start-while-busy, operand scrambling and back-to-back issue.
module tb_muldiv_unit;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.DW(DW)) bus ();

    muldiv_unit #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MTHI/MTLO issued from IDLE; result visible right after the sampling edge.
    task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] eh, input logic [31:0] el);
        bus.start = 1'b1; bus.op = o; bus.A = a;
        tick();
        bus.start = 1'b0;
        chk({tag, " hi"}, bus.hi, eh);
        chk({tag, " lo"}, bus.lo, el);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " done"}, bus.done, 0);
    endtask

    // mode 0: quiet; 1: scramble inputs during CALC; 2: MTHI and MULT attempts during CALC.
    // Returns in the done cycle so callers may issue back-to-back.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int mode);
        logic [31:0] hi0, lo0;
        int bc;
        bit moved, early;
        hi0 = bus.hi; lo0 = bus.lo;
        moved = 0; early = 0; bc = 0;
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        tick();
        bus.start = 1'b0;
        while (bus.busy && bc < 200) begin
            bc++;
            if (bus.done) early = 1;
            if (bus.hi !== hi0 || bus.lo !== lo0) moved = 1;
            if (mode == 1) begin
                bus.A = $urandom; bus.B = $urandom; bus.op = 3'($urandom_range(0, 7));
            end else if (mode == 2) begin
                if (bc == 5) begin bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'hDEAD; end
                else if (bc == 6) begin bus.op = 3'd0; bus.A = 32'd9; bus.B = 32'd9; end
                else bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        chk({tag, " busy cycles"}, bc, DW + 1);
        chk({tag, " no early done"}, early, 0);
        chk({tag, " hi/lo held"}, moved, 0);
        chk({tag, " done"}, bus.done, 1);
        chk({tag, " hi"}, bus.hi, eh);
        chk({tag, " lo"}, bus.lo, el);
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0; bus.op = 3'd7; bus.A = '0; bus.B = '0;
        tick(); tick();
        chk("reset hi", bus.hi, 0);
        chk("reset lo", bus.lo, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        rst = 1'b1;
        tick();

        mt("mthi idle", 3'd4, 32'hBEEF, 32'hBEEF, 32'h0);
        mt("mtlo idle", 3'd5, 32'h1111, 32'hBEEF, 32'h1111);
        bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'h7777;
        tick();
        bus.start = 1'b0;
        chk("nop hi", bus.hi, 32'hBEEF);
        chk("nop busy", bus.busy, 0);

        // Reset in the middle of a DIV aborts without touching HI/LO beyond the reset clear.
        bus.start = 1'b1; bus.op = 3'd2; bus.A = -32'sd7; bus.B = 32'd2;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("abort hi", bus.hi, 0);
        chk("abort lo", bus.lo, 0);
        chk("abort busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) seen = 1;
            tick();
        end
        chk("abort no done", seen, 0);
        run_op("multu 3*4", 3'd1, 32'd3, 32'd4, 32'h0, 32'd12, 0);
        tick();
        chk("done one cycle", bus.done, 0);

        run_op("mult -3*5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        tick();
        run_op("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0);
        tick();
        run_op("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        tick();
        run_op("divu 100/7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        tick();
        run_op("div min/-1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
        tick();
        run_op("divu by 0", 3'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 0);
        tick();
        run_op("div -5 by 0", 3'd2, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        tick();
        run_op("start while busy", 3'd0, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6, 2);
        tick();
        run_op("scrambled inputs", 3'd3, 32'd1000, 32'd33, 32'd10, 32'd30, 1);
        // Next op and then an MTHI issued in the done cycle.
        run_op("back-to-back", 3'd0, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 0);
        mt("mthi in done cycle", 3'd4, 32'h55, 32'h55, 32'h0);
        tick();
        chk("final done", bus.done, 0);
        chk("final busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
